// File: rtl/apb_pkg.sv
// Types and defaults shared by the bridge blocks (apb_master, apb_slave, I2C front end).
package apb_pkg;

  localparam int APB_ADDR_W = 7;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expire_o flags the cycle whose increment reaches the limit.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is decided in the same cycle the count would reach the limit,
  // so a pready arriving in that cycle (en_i low) still completes normally.
  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    assign expire_o = 1'b0;
  end else begin : g_enabled
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign expire_o = en_i && (count_q >= LAST);
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator for the I2C-to-APB bridge: one command in, one SETUP/ACCESS transfer, one response out.
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, address/data/direction presented
// ACCESS | penable high, waiting for pready or watchdog expiry
// RESP   | bus released, response held until rsp_ready
module apb_master
  import apb_pkg::*;
#(
  parameter int          ADDR_W         = APB_ADDR_W,
  parameter int          DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic              apb_pread,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr
);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic              pread_q, pread_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  apb_rsp_t          rsp_q, rsp_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expire;

  assign timer_clr = (state_q == SETUP);
  assign timer_en  = (state_q == ACCESS) && !apb_pready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pread_d     = pread_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          pread_d     = !cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (apb_pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pwrite_d      = 1'b0;
          pread_d       = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_d.rdata   = pread_q ? APB_DATA_W'(apb_prdata) : '0;
          rsp_d.err     = apb_pslverr;
          rsp_d.timeout = 1'b0;
        end else if (timer_expire) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pwrite_d      = 1'b0;
          pread_d       = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pread_q     <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pread_q     <= pread_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_pread   = pread_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: cycle-exact checks of handshakes, latency, errors, watchdog and reset.
module tb_apb_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       apb_psel;
  logic       apb_penable;
  logic       apb_pwrite;
  logic       apb_pread;
  logic [6:0] apb_paddr;
  logic [7:0] apb_pwdata;
  logic [7:0] apb_prdata;
  logic       apb_pready;
  logic       apb_pslverr;

  int checks   = 0;
  int failures = 0;

  apb_master #(
    .ADDR_W(7),
    .DATA_W(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_pread   (apb_pread),
    .apb_paddr   (apb_paddr),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite, pread}
  function automatic logic [31:0] flags();
    return 32'({cmd_ready, rsp_valid, rsp_err, rsp_timeout,
                apb_psel, apb_penable, apb_pwrite, apb_pread});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Accept in cycle 0, SETUP in 1, ACCESS in 2..2+waits, RESP in 3+waits.
  task automatic do_xfer(input string tag, input logic wr, input logic [6:0] addr,
                         input logic [7:0] wd, input logic [7:0] slv_rd, input int waits,
                         input logic slverr, input logic [7:0] exp_rd, input logic exp_err);
    check({tag, "_idle"}, 32'({cmd_ready, apb_psel, rsp_valid}), 32'(3'b100));
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_addr    = addr;
    cmd_wdata   = wd;
    apb_pready  = (waits == 0);
    apb_prdata  = (waits == 0) ? slv_rd : 8'hEE;
    apb_pslverr = (waits == 0) ? slverr : 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wd;
    check({tag, "_setup"}, 32'({cmd_ready, rsp_valid, apb_psel, apb_penable, apb_pwrite, apb_pread}),
          32'({4'b0010, wr, ~wr}));
    check({tag, "_setup_addr"}, 32'(apb_paddr), 32'(addr));
    check({tag, "_setup_wdata"}, 32'(apb_pwdata), wr ? 32'(wd) : 32'd0);
    tick();
    for (int i = 0; i < waits; i++) begin
      check({tag, "_wait"}, 32'({cmd_ready, rsp_valid, apb_psel, apb_penable, apb_pwrite, apb_pread}),
            32'({4'b0011, wr, ~wr}));
      check({tag, "_wait_addr"}, 32'(apb_paddr), 32'(addr));
      tick();
    end
    check({tag, "_access"}, 32'({cmd_ready, rsp_valid, apb_psel, apb_penable, apb_pwrite, apb_pread}),
          32'({4'b0011, wr, ~wr}));
    check({tag, "_access_addr"}, 32'(apb_paddr), 32'(addr));
    apb_pready  = 1'b1;
    apb_prdata  = slv_rd;
    apb_pslverr = slverr;
    tick();
    check({tag, "_resp"}, flags(), 32'({2'b01, exp_err, 5'b00000}));
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    apb_pready  = 1'b0;
    apb_pslverr = 1'b0;
    apb_prdata  = 8'h00;
    rsp_ready   = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done"}, 32'({cmd_ready, rsp_valid, apb_psel}), 32'(3'b100));
    check({tag, "_addr_hold"}, 32'(apb_paddr), 32'(addr));
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    apb_prdata  = '0;
    apb_pready  = 1'b0;
    apb_pslverr = 1'b0;

    tick();
    check("reset_flags", flags(), 32'h80);
    check("reset_paddr", 32'(apb_paddr), 32'd0);
    check("reset_pwdata", 32'(apb_pwdata), 32'd0);
    check("reset_rdata", 32'(rsp_rdata), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_xfer("wr32", 1'b1, 7'h32, 8'hAA, 8'h55, 0, 1'b0, 8'h00, 1'b0);
    check("pwdata_hold", 32'(apb_pwdata), 32'hAA);
    do_xfer("rd32", 1'b0, 7'h32, 8'h11, 8'hAA, 0, 1'b0, 8'hAA, 1'b0);
    check("pwdata_read_zero", 32'(apb_pwdata), 32'h00);
    do_xfer("rd33", 1'b0, 7'h33, 8'h22, 8'hAB, 0, 1'b0, 8'hAB, 1'b0);
    do_xfer("rd_wait3", 1'b0, 7'h40, 8'h00, 8'h5C, 3, 1'b0, 8'h5C, 1'b0);
    do_xfer("wr_slverr", 1'b1, 7'h64, 8'h3C, 8'h00, 0, 1'b1, 8'h00, 1'b1);
    do_xfer("wr_after_err", 1'b1, 7'h05, 8'h99, 8'h00, 0, 1'b0, 8'h00, 1'b0);
    do_xfer("rd_wait15", 1'b0, 7'h7F, 8'h00, 8'hC3, 15, 1'b0, 8'hC3, 1'b0);

    // Watchdog: pready never arrives; RESP follows the 16th ACCESS cycle.
    check("to_idle", 32'({cmd_ready, apb_psel}), 32'(2'b10));
    cmd_valid  = 1'b1;
    cmd_write  = 1'b0;
    cmd_addr   = 7'h10;
    apb_pready = 1'b0;
    apb_prdata = 8'h77;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("to_access", 32'({cmd_ready, rsp_valid, apb_psel, apb_penable}), 32'(4'b0011));
      tick();
    end
    check("to_resp", flags(), 32'b0111_0000);
    check("to_rdata", 32'(rsp_rdata), 32'd0);

    // Backpressure with a competing command that must be ignored.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 7'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_flags", flags(), 32'b0111_0000);
      check("bp_rdata", 32'(rsp_rdata), 32'd0);
      check("bp_paddr", 32'(apb_paddr), 32'h10);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release", 32'({cmd_ready, rsp_valid, apb_psel}), 32'(3'b100));

    // Reset while a read waits in ACCESS.
    cmd_valid  = 1'b1;
    cmd_write  = 1'b0;
    cmd_addr   = 7'h2A;
    apb_pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_mid_access", 32'({apb_psel, apb_penable}), 32'(2'b11));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_flags", flags(), 32'h80);
    check("rst_mid_paddr", 32'(apb_paddr), 32'd0);
    apb_pready = 1'b1;
    apb_prdata = 8'h99;
    tick();
    check("rst_no_rsp", flags(), 32'h80);
    apb_pready = 1'b0;
    tick();

    do_xfer("wr_post_rst", 1'b1, 7'h21, 8'h42, 8'h00, 0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
